// File: rtl/echo_mixer_pkg.sv
// Shared audio types for the echo mixer.
// Sample, gain and ramp-state definitions.
package aurras_audio_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [7:0] gain_t;

  typedef enum logic [1:0] {
    OFF,
    RAMP_UP,
    ACTIVE,
    RAMP_DOWN
  } mix_state_t;

  localparam sample_t SAMPLE_MAX = 16'sd32767;
  localparam sample_t SAMPLE_MIN = -16'sd32768;

endpackage

// File: rtl/echo_mixer_if.sv
// Sample stream bundle between delay line,
// mixer and audio output path.
interface echo_mixer_if;
  import aurras_audio_pkg::*;

  logic    audio_valid_in;
  sample_t audio_in;
  sample_t echo_in;
  sample_t signal_out;
  logic    valid_out;

  modport master (
    output audio_valid_in,
    output audio_in,
    output echo_in,
    input  signal_out,
    input  valid_out
  );

  modport slave (
    input  audio_valid_in,
    input  audio_in,
    input  echo_in,
    output signal_out,
    output valid_out
  );

endinterface

// File: rtl/echo_mixer_gain_ramp.sv
// Gain ramp FSM: walks gain_eff toward the
// target one step per accepted sample.
module gain_ramp
  import aurras_audio_pkg::*;
#(
  parameter int RAMP_STEP = 1
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  step_in,
  input  logic  enable_in,
  input  gain_t target_in,
  output gain_t gain_eff_out,
  output logic  busy_out
);

  localparam gain_t STEP = gain_t'(RAMP_STEP);

  mix_state_t state_q;
  mix_state_t state_d;
  gain_t      gain_q;
  gain_t      gain_d;
  gain_t      up_gap;
  gain_t      dn_gap;
  gain_t      toward;
  gain_t      to_zero;
  mix_state_t settle;

  assign up_gap = target_in - gain_q;
  assign dn_gap = gain_q - target_in;

  // One step toward target, or toward zero
  always_comb begin
    toward = gain_q;
    if (target_in > gain_q)
      toward = gain_q + ((up_gap < STEP) ? up_gap : STEP);
    else if (target_in < gain_q)
      toward = gain_q - ((dn_gap < STEP) ? dn_gap : STEP);
    to_zero = (gain_q < STEP) ? '0 : gain_q - STEP;
    settle = (target_in == '0) ? OFF : ACTIVE;
  end

  // Next state/gain, only moves on a step strobe
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (step_in) begin
      unique case (state_q)
        OFF: begin
          if (enable_in && target_in != '0) begin
            gain_d  = toward;
            state_d = (toward == target_in) ? ACTIVE : RAMP_UP;
          end
        end
        RAMP_UP, ACTIVE: begin
          if (!enable_in) begin
            gain_d  = to_zero;
            state_d = (to_zero == '0) ? OFF : RAMP_DOWN;
          end else begin
            gain_d  = toward;
            if (toward == target_in)
              state_d = settle;
          end
        end
        RAMP_DOWN: begin
          if (enable_in) begin
            gain_d  = toward;
            state_d = (toward == target_in) ? settle : RAMP_UP;
          end else begin
            gain_d  = to_zero;
            state_d = (to_zero == '0) ? OFF : RAMP_DOWN;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  // State, gain and busy flag registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= OFF;
      gain_q   <= '0;
      busy_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      busy_out <= (state_d == RAMP_UP) ||
                  (state_d == RAMP_DOWN);
    end
  end

  assign gain_eff_out = gain_q;

endmodule

// File: rtl/echo_mixer.sv
// Echo mixer: live +/- gain-scaled echo, saturated.
// Option ECHO_MIXER_CLIP_COUNT_EN adds clip reporting.
module echo_mixer
  import aurras_audio_pkg::*;
#(
  parameter int ECHO_LATENCY = 2,
  parameter int RAMP_STEP    = 1
) (
  input  logic  clk_in,
  input  logic  rst_in,
  echo_mixer_if.slave bus,
  input  logic  enable_in,
  input  logic  subtract_in,
  input  gain_t gain_in,
  output gain_t gain_eff_out,
  output logic  ramp_busy_out,
`ifdef ECHO_MIXER_CLIP_COUNT_EN
  output logic [15:0] clip_count_out,
  output logic        clip_out,
`endif
  output logic  overrun_out
);

  localparam logic [3:0] CAP_AT = 4'(ECHO_LATENCY);
  localparam logic [3:0] OUT_AT = 4'(ECHO_LATENCY + 1);
  localparam logic [3:0] END_AT = 4'(ECHO_LATENCY + 2);

  logic               busy_q;
  logic [3:0]         cnt_q;
  sample_t            live_q;
  logic               sub_q;
  gain_t              gain_q;
  logic signed [16:0] scaled_q;
  logic signed [24:0] prod;
  logic signed [16:0] live_ext;
  logic signed [16:0] sum;
  sample_t            sat;
  logic               clip;
  logic               accept;

  assign accept = bus.audio_valid_in && !busy_q;

  gain_ramp #(
    .RAMP_STEP(RAMP_STEP)
  ) u_ramp (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .step_in     (accept),
    .enable_in   (enable_in),
    .target_in   (gain_in),
    .gain_eff_out(gain_eff_out),
    .busy_out    (ramp_busy_out)
  );

  // Scale echo by unsigned Q0.8 gain, then mix and clamp
  always_comb begin
    prod = bus.echo_in * $signed({1'b0, gain_q});
    live_ext = {live_q[15], live_q};
    sum = sub_q ? live_ext - scaled_q
                : live_ext + scaled_q;
    clip = 1'b0;
    sat  = sum[15:0];
    if (sum > 17'sd32767) begin
      sat  = SAMPLE_MAX;
      clip = 1'b1;
    end else if (sum < -17'sd32768) begin
      sat  = SAMPLE_MIN;
      clip = 1'b1;
    end
  end

  // Alignment pipeline: latch, wait for echo, scale, mix
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q         <= 1'b0;
      cnt_q          <= '0;
      live_q         <= '0;
      sub_q          <= 1'b0;
      gain_q         <= '0;
      scaled_q       <= '0;
      bus.signal_out <= '0;
      bus.valid_out  <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      bus.valid_out <= 1'b0;
      if (bus.audio_valid_in && busy_q)
        overrun_out <= 1'b1;
      if (accept) begin
        busy_q <= 1'b1;
        cnt_q  <= 4'd1;
        live_q <= bus.audio_in;
        sub_q  <= subtract_in;
        gain_q <= gain_eff_out;
      end else if (busy_q) begin
        if (cnt_q == CAP_AT)
          scaled_q <= prod[24:8];
        if (cnt_q == OUT_AT) begin
          bus.signal_out <= sat;
          bus.valid_out  <= 1'b1;
        end
        if (cnt_q == END_AT) begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

`ifdef ECHO_MIXER_CLIP_COUNT_EN
  // Clip flag with output strobe, saturating counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clip_out       <= 1'b0;
      clip_count_out <= '0;
    end else begin
      clip_out <= 1'b0;
      if (busy_q && !accept && cnt_q == OUT_AT) begin
        clip_out <= clip;
        if (clip && clip_count_out != 16'hFFFF)
          clip_count_out <= clip_count_out + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_echo_mixer.sv
// Scoreboard bench for echo_mixer.
// Directed vectors, monitor pops on valid_out.
module tb_echo_mixer;
  import aurras_audio_pkg::*;

  localparam int L = 2;

  typedef struct {
    int v;
    int due;
  } exp_t;

  logic  clk_in = 1'b0;
  logic  rst_in = 1'b1;
  logic  enable_in = 1'b0;
  logic  subtract_in = 1'b0;
  gain_t gain_in = '0;
  gain_t gain_eff_out;
  logic  ramp_busy_out;
  logic  overrun_out;
`ifdef ECHO_MIXER_CLIP_COUNT_EN
  logic [15:0] clip_count_out;
  logic        clip_out;
  int          clip_base;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  echo_mixer_if bus ();

  echo_mixer #(
    .ECHO_LATENCY(L),
    .RAMP_STEP(1)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .bus          (bus),
    .enable_in    (enable_in),
    .subtract_in  (subtract_in),
    .gain_in      (gain_in),
    .gain_eff_out (gain_eff_out),
    .ramp_busy_out(ramp_busy_out),
`ifdef ECHO_MIXER_CLIP_COUNT_EN
    .clip_count_out(clip_count_out),
    .clip_out     (clip_out),
`endif
    .overrun_out  (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void chk(string n, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, got, want);
    end
  endfunction

  // Monitor: every output strobe must match the queue head
  always @(negedge clk_in) begin
    if (bus.valid_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got %0d want none",
                 int'(bus.signal_out));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("signal_out", int'(bus.signal_out), e.v);
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic send(input int a, input int e,
                      input logic s, input int want);
    exp_t x;
    @(negedge clk_in);
    bus.audio_valid_in = 1'b1;
    bus.audio_in = sample_t'(a);
    bus.echo_in = sample_t'(e);
    subtract_in = s;
    x.v = want;
    x.due = cyc + L + 2;
    q.push_back(x);
    @(negedge clk_in);
    bus.audio_valid_in = 1'b0;
    repeat (L + 3) @(negedge clk_in);
  endtask

  initial begin
    bus.audio_valid_in = 1'b0;
    bus.audio_in = '0;
    bus.echo_in = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_signal", int'(bus.signal_out), 0);
    chk("rst_valid", int'(bus.valid_out), 0);
    chk("rst_gain", int'(gain_eff_out), 0);
    chk("rst_busy", int'(ramp_busy_out), 0);
    chk("rst_overrun", int'(overrun_out), 0);

    send(1234, -500, 1'b0, 1234);
    chk("pass_gain", int'(gain_eff_out), 0);

    gain_in = 8'd4;
    enable_in = 1'b1;
    send(1000, 256, 1'b0, 1000);
    chk("up1_gain", int'(gain_eff_out), 1);
    chk("up1_busy", int'(ramp_busy_out), 1);
    send(1000, 256, 1'b0, 1001);
    send(1000, 256, 1'b0, 1002);
    chk("up3_busy", int'(ramp_busy_out), 1);
    send(1000, 256, 1'b0, 1003);
    chk("up4_gain", int'(gain_eff_out), 4);
    chk("up4_busy", int'(ramp_busy_out), 0);
    send(1000, 256, 1'b0, 1004);
    chk("act_gain", int'(gain_eff_out), 4);

    enable_in = 1'b0;
    send(1000, 256, 1'b0, 1004);
    chk("dn1_gain", int'(gain_eff_out), 3);
    chk("dn1_busy", int'(ramp_busy_out), 1);
    send(1000, 256, 1'b0, 1003);
    send(1000, 256, 1'b0, 1002);
    send(1000, 256, 1'b0, 1001);
    chk("dn4_gain", int'(gain_eff_out), 0);
    chk("dn4_busy", int'(ramp_busy_out), 0);

    gain_in = 8'd1;
    enable_in = 1'b1;
    send(5, 0, 1'b0, 5);
    chk("g1_gain", int'(gain_eff_out), 1);
    send(0, -1, 1'b0, -1);

    gain_in = 8'd128;
    for (int i = 0; i < 127; i++)
      send(i, 0, 1'b0, i);
    chk("g128_gain", int'(gain_eff_out), 128);
    chk("g128_busy", int'(ramp_busy_out), 0);
    send(1000, 2000, 1'b1, 0);
    send(100, -301, 1'b0, -51);

    gain_in = 8'd255;
    for (int i = 0; i < 127; i++)
      send(-i, 0, 1'b1, -i);
    chk("g255_gain", int'(gain_eff_out), 255);
`ifdef ECHO_MIXER_CLIP_COUNT_EN
    clip_base = int'(clip_count_out);
`endif
    send(30000, 20000, 1'b0, 32767);
    send(-32768, 20000, 1'b1, -32768);
    send(-32768, -1, 1'b1, -32767);
`ifdef ECHO_MIXER_CLIP_COUNT_EN
    chk("clip_count", int'(clip_count_out), clip_base + 2);
`endif

    chk("pre_overrun", int'(overrun_out), 0);
    @(negedge clk_in);
    bus.audio_valid_in = 1'b1;
    bus.audio_in = 16'sd500;
    bus.echo_in = '0;
    subtract_in = 1'b0;
    begin
      exp_t x;
      x.v = 500;
      x.due = cyc + L + 2;
      q.push_back(x);
    end
    @(negedge clk_in);
    bus.audio_in = 16'sd777;
    @(negedge clk_in);
    bus.audio_valid_in = 1'b0;
    repeat (L + 4) @(negedge clk_in);
    chk("overrun_set", int'(overrun_out), 1);
    for (int i = 0; i < 10; i++)
      send(i * 10, 0, 1'b0, i * 10);
    chk("overrun_sticky", int'(overrun_out), 1);

    @(negedge clk_in);
    bus.audio_valid_in = 1'b1;
    bus.audio_in = 16'sd4321;
    @(negedge clk_in);
    bus.audio_valid_in = 1'b0;
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (L + 4) @(negedge clk_in);
    chk("mrst_signal", int'(bus.signal_out), 0);
    chk("mrst_valid", int'(bus.valid_out), 0);
    chk("mrst_gain", int'(gain_eff_out), 0);
    chk("mrst_busy", int'(ramp_busy_out), 0);
    chk("mrst_overrun", int'(overrun_out), 0);
`ifdef ECHO_MIXER_CLIP_COUNT_EN
    chk("mrst_clip", int'(clip_count_out), 0);
`endif

    enable_in = 1'b0;
    send(77, 500, 1'b0, 77);
    chk("post_gain", int'(gain_eff_out), 0);

    repeat (4) @(negedge clk_in);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
